// File: rtl/fault_syndrome_collector.sv
// Response-compaction stage for the good/faulty c5315 pair: builds a per-fault
// pass/fail syndrome (one bit per pattern) and keeps fault and detection counts.
module fault_syndrome_collector #(
    parameter int unsigned OUT_W    = 123,
    parameter int unsigned TEST_CNT = 124,
    parameter int unsigned CNT_W    = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fault_start,
    input  logic                vec_valid,
    input  logic                vec_last,
    input  logic [OUT_W-1:0]    good_out,
    input  logic [OUT_W-1:0]    faulty_out,
    input  logic                clear_stats,
    output logic                busy,
    output logic [TEST_CNT-1:0] syndrome,
    output logic                syn_valid,
    output logic                detected,
    output logic [7:0]          pat_count,
    output logic [CNT_W-1:0]    fault_count,
    output logic [CNT_W-1:0]    det_count,
    output logic                pat_ovf
);

    localparam int unsigned PAT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic [TEST_CNT-1:0] r_work_syn;
    logic [PAT_W-1:0]    r_pat_count;
    logic [TEST_CNT-1:0] r_syndrome;
    logic                r_detected;
    logic                r_syn_valid;
    logic [CNT_W-1:0]    r_fault_count;
    logic [CNT_W-1:0]    r_det_count;
    logic                r_pat_ovf;

    state_t              w_state_nxt;
    logic [TEST_CNT-1:0] w_work_nxt;
    logic [PAT_W-1:0]    w_pat_nxt;
    logic [TEST_CNT-1:0] w_syn_nxt;
    logic                w_det_nxt;
    logic                w_sv_nxt;
    logic [CNT_W-1:0]    w_fc_nxt;
    logic [CNT_W-1:0]    w_dc_nxt;
    logic                w_ovf_nxt;
    logic                w_full;
    logic                w_mismatch;
    logic [TEST_CNT-1:0] w_final_syn;

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_work_syn    <= '0;
            r_pat_count   <= '0;
            r_syndrome    <= '0;
            r_detected    <= 1'b0;
            r_syn_valid   <= 1'b0;
            r_fault_count <= '0;
            r_det_count   <= '0;
            r_pat_ovf     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= (w_state_nxt == ST_COLLECT);
            r_work_syn    <= w_work_nxt;
            r_pat_count   <= w_pat_nxt;
            r_syndrome    <= w_syn_nxt;
            r_detected    <= w_det_nxt;
            r_syn_valid   <= w_sv_nxt;
            r_fault_count <= w_fc_nxt;
            r_det_count   <= w_dc_nxt;
            r_pat_ovf     <= w_ovf_nxt;
        end
    end

    // Next-state and result computation
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work_syn;
        w_pat_nxt   = r_pat_count;
        w_syn_nxt   = r_syndrome;
        w_det_nxt   = r_detected;
        w_sv_nxt    = 1'b0;
        w_fc_nxt    = r_fault_count;
        w_dc_nxt    = r_det_count;
        w_ovf_nxt   = r_pat_ovf;

        w_full      = (r_pat_count == PAT_W'(TEST_CNT));
        w_mismatch  = (good_out != faulty_out);
        // Unwritten working bits are always 0, so OR-ing in the new bit is enough
        w_final_syn = r_work_syn;
        if (w_mismatch && !w_full) begin
            w_final_syn = r_work_syn | (TEST_CNT'(1) << r_pat_count);
        end

        case (r_state)
            ST_IDLE: begin
                if (fault_start) begin
                    w_work_nxt  = '0;
                    w_pat_nxt   = '0;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (vec_valid) begin
                    if (w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_work_nxt = w_final_syn;
                        w_pat_nxt  = r_pat_count + PAT_W'(1);
                    end
                    if (vec_last) begin
                        w_syn_nxt   = w_final_syn;
                        w_det_nxt   = |w_final_syn;
                        w_sv_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                        if (r_fault_count != '1) begin
                            w_fc_nxt = r_fault_count + CNT_W'(1);
                        end
                        if ((|w_final_syn) && (r_det_count != '1)) begin
                            w_dc_nxt = r_det_count + CNT_W'(1);
                        end
                    end
                end
                // Abort, or back-to-back restart after a coincident completion
                if (fault_start) begin
                    w_work_nxt  = '0;
                    w_pat_nxt   = '0;
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (clear_stats) begin
            w_fc_nxt  = '0;
            w_dc_nxt  = '0;
            w_ovf_nxt = 1'b0;
        end
    end

    assign busy        = r_busy;
    assign syndrome    = r_syndrome;
    assign syn_valid   = r_syn_valid;
    assign detected    = r_detected;
    assign pat_count   = r_pat_count;
    assign fault_count = r_fault_count;
    assign det_count   = r_det_count;
    assign pat_ovf     = r_pat_ovf;

endmodule

// File: tb/tb_fault_syndrome_collector.sv
// Randomized self-checking bench for fault_syndrome_collector against a
// queue-based reference model of the per-fault syndrome and statistics.
module tb_fault_syndrome_collector;

    localparam int unsigned OUT_W    = 123;
    localparam int unsigned TEST_CNT = 124;
    localparam int unsigned CNT_W    = 13;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                fault_start;
    logic                vec_valid;
    logic                vec_last;
    logic [OUT_W-1:0]    good_out;
    logic [OUT_W-1:0]    faulty_out;
    logic                clear_stats;
    logic                busy;
    logic [TEST_CNT-1:0] syndrome;
    logic                syn_valid;
    logic                detected;
    logic [7:0]          pat_count;
    logic [CNT_W-1:0]    fault_count;
    logic [CNT_W-1:0]    det_count;
    logic                pat_ovf;

    fault_syndrome_collector #(
        .OUT_W    (OUT_W),
        .TEST_CNT (TEST_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fault_start (fault_start),
        .vec_valid   (vec_valid),
        .vec_last    (vec_last),
        .good_out    (good_out),
        .faulty_out  (faulty_out),
        .clear_stats (clear_stats),
        .busy        (busy),
        .syndrome    (syndrome),
        .syn_valid   (syn_valid),
        .detected    (detected),
        .pat_count   (pat_count),
        .fault_count (fault_count),
        .det_count   (det_count),
        .pat_ovf     (pat_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: responses of the current/last fault kept as a list of pass/fail bits
    bit                  m_q[$];
    bit                  m_busy;
    logic [TEST_CNT-1:0] m_syn;
    bit                  m_det;
    bit                  m_sv;
    int                  m_fc;
    int                  m_dc;
    bit                  m_ovf;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_syn  = '0;
        m_det  = 0;
        m_sv   = 0;
        m_fc   = 0;
        m_dc   = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step(input bit fs, input bit vv, input bit vl, input bit mm, input bit cs);
        m_sv = 0;
        if (!m_busy) begin
            if (fs) begin
                m_q.delete();
                m_busy = 1;
            end
        end else begin
            if (vv) begin
                if (m_q.size() < TEST_CNT) m_q.push_back(mm);
                else m_ovf = 1;
                if (vl) begin
                    m_syn = '0;
                    foreach (m_q[i]) m_syn[i] = m_q[i];
                    m_det = (m_syn != '0);
                    m_sv  = 1;
                    m_fc  = (m_fc + 1 > CNT_MAX) ? CNT_MAX : m_fc + 1;
                    if (m_det) m_dc = (m_dc + 1 > CNT_MAX) ? CNT_MAX : m_dc + 1;
                    m_busy = 0;
                end
            end
            if (fs) begin
                m_q.delete();
                m_busy = 1;
            end
        end
        if (cs) begin
            m_fc  = 0;
            m_dc  = 0;
            m_ovf = 0;
        end
    endtask

    task automatic compare_all();
        check("busy",        128'(busy),        128'(m_busy));
        check("syn_valid",   128'(syn_valid),   128'(m_sv));
        check("syndrome",    128'(syndrome),    128'(m_syn));
        check("detected",    128'(detected),    128'(m_det));
        check("pat_count",   128'(pat_count),   128'(m_q.size()));
        check("fault_count", 128'(fault_count), 128'(m_fc));
        check("det_count",   128'(det_count),   128'(m_dc));
        check("pat_ovf",     128'(pat_ovf),     128'(m_ovf));
    endtask

    // One clock cycle: drive inputs, advance model, check after the edge
    task automatic cyc(input bit fs, input bit vv, input bit vl, input logic [OUT_W-1:0] flip, input bit cs);
        logic [OUT_W-1:0] g;
        g = OUT_W'({$urandom, $urandom, $urandom, $urandom});
        fault_start = fs;
        vec_valid   = vv;
        vec_last    = vl;
        good_out    = g;
        faulty_out  = g ^ flip;
        clear_stats = cs;
        model_step(fs, vv, vl, (flip != '0), cs);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [OUT_W-1:0] rand_flip();
        return OUT_W'(1) << $urandom_range(0, OUT_W - 1);
    endfunction

    logic [OUT_W-1:0] bit122;
    logic [OUT_W-1:0] fl;

    initial begin
        rst_n       = 1'b0;
        fault_start = 1'b0;
        vec_valid   = 1'b0;
        vec_last    = 1'b0;
        good_out    = '0;
        faulty_out  = '0;
        clear_stats = 1'b0;
        bit122      = OUT_W'(1) << 122;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Full-length clean fault
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < TEST_CNT; i++) cyc(0, 1, (i == TEST_CNT - 1), '0, 0);
        cyc(0, 0, 0, '0, 0);

        // Mismatches at patterns 0, 5 and 123 on output bit 122
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < TEST_CNT; i++)
            cyc(0, 1, (i == TEST_CNT - 1), (i == 0 || i == 5 || i == 123) ? bit122 : '0, 0);
        cyc(0, 0, 0, '0, 0);

        // Short fault, mismatch on the last pattern
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, (i == 2), (i == 2) ? rand_flip() : '0, 0);
        cyc(0, 0, 0, '0, 0);

        // Abort after 10 mismatching vectors, then 4 clean vectors
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, rand_flip(), 0);
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, (i == 3), '0, 0);
        cyc(0, 0, 0, '0, 0);

        // Overflow: 125 vectors, then clear_stats
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < TEST_CNT + 1; i++) cyc(0, 1, (i == TEST_CNT), rand_flip(), 0);
        cyc(0, 0, 0, '0, 0);
        cyc(0, 0, 0, '0, 1);
        cyc(0, 1, 1, rand_flip(), 0);

        // Asynchronous reset mid-collection
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, rand_flip(), 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        cyc(0, 1, 1, rand_flip(), 0);
        cyc(0, 1, 0, rand_flip(), 0);

        // Randomized faults with gaps, aborts, noise and occasional clears
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 130);
            repeat ($urandom_range(0, 2)) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), rand_flip(), 0);
            cyc(1, 0, 0, '0, 0);
            for (int p = 0; p < len; p++) begin
                if ($urandom_range(0, 9) == 0) cyc(0, 0, $urandom_range(0, 1), rand_flip(), 0);
                fl = ($urandom_range(0, 3) == 0) ? rand_flip() : '0;
                cyc(($urandom_range(0, 99) < 2), 1, (p == len - 1), fl, ($urandom_range(0, 99) < 3));
            end
        end
        cyc(0, 0, 0, '0, 1);

        // Back-to-back single-pattern faults driving both counters into saturation
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < CNT_MAX + 5; i++) cyc(1, 1, 1, rand_flip(), 0);
        cyc(0, 1, 1, '0, 0);
        cyc(0, 0, 0, '0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
